// File: rtl/rect_fill_engine.sv
// Rectangle-fill sequencer: walks an inclusive rectangle in row-major order and
// issues one video RAM write per pixel through a request/grant port.
module rect_fill_engine #(
    parameter int H_RES   = 80,
    parameter int V_RES   = 60,
    parameter int COLOR_W = 3,
    parameter int ADDR_W  = 13
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               iStart,
    input  logic               iAbort,
    input  logic [15:0]        iX0,
    input  logic [15:0]        iY0,
    input  logic [15:0]        iX1,
    input  logic [15:0]        iY1,
    input  logic [COLOR_W-1:0] iColor,
    output logic               oBusy,
    output logic               oDone,
    output logic               oError,
    output logic               oWriteReq,
    input  logic               iWriteGrant,
    output logic [ADDR_W-1:0]  oWriteAddress,
    output logic [COLOR_W-1:0] oWriteData
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_FILL = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [15:0]       H_RES_16 = 16'(H_RES);
    localparam logic [15:0]       V_RES_16 = 16'(V_RES);
    localparam logic [ADDR_W-1:0] H_RES_A  = ADDR_W'(H_RES);

    state_t               state_q, state_d;
    logic [15:0]          x0_q, x0_d, y0_q, y0_d, x1_q, x1_d, y1_q, y1_d;
    logic [15:0]          x_q, x_d, y_q, y_d;
    logic [ADDR_W-1:0]    row_base_q, row_base_d;
    logic [COLOR_W-1:0]   color_q, color_d;
    logic                 err_q, err_d;
    logic                 cmd_bad_s;
    logic                 last_pixel_s;

    assign cmd_bad_s    = (x0_q > x1_q) || (y0_q > y1_q) ||
                          (x1_q >= H_RES_16) || (y1_q >= V_RES_16);
    assign last_pixel_s = (x_q == x1_q) && (y_q == y1_q);

    // State register and command/walk registers.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q    <= S_IDLE;
            x0_q       <= 16'd0;
            y0_q       <= 16'd0;
            x1_q       <= 16'd0;
            y1_q       <= 16'd0;
            x_q        <= 16'd0;
            y_q        <= 16'd0;
            row_base_q <= '0;
            color_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            x0_q       <= x0_d;
            y0_q       <= y0_d;
            x1_q       <= x1_d;
            y1_q       <= y1_d;
            x_q        <= x_d;
            y_q        <= y_d;
            row_base_q <= row_base_d;
            color_q    <= color_d;
            err_q      <= err_d;
        end
    end

    // Next-state logic: command latch, validation and pixel walk.
    always_comb begin
        state_d    = state_q;
        x0_d       = x0_q;
        y0_d       = y0_q;
        x1_d       = x1_q;
        y1_d       = y1_q;
        x_d        = x_q;
        y_d        = y_q;
        row_base_d = row_base_q;
        color_d    = color_q;
        err_d      = err_q;
        case (state_q)
            S_IDLE: begin
                if (iStart) begin
                    x0_d    = iX0;
                    y0_d    = iY0;
                    x1_d    = iX1;
                    y1_d    = iY1;
                    color_d = iColor;
                    err_d   = 1'b0;
                    state_d = S_LOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                // A rejected command reports its error even if aborted at the same time.
                if (cmd_bad_s) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else if (iAbort) begin
                    state_d = S_DONE;
                end else begin
                    row_base_d = ADDR_W'(y0_q) * H_RES_A;
                    x_d        = x0_q;
                    y_d        = y0_q;
                    state_d    = S_FILL;
                end
            end
            S_FILL: begin
                if (iWriteGrant) begin
                    if (x_q < x1_q) begin
                        x_d = x_q + 16'd1;
                    end else if (y_q < y1_q) begin
                        x_d        = x0_q;
                        y_d        = y_q + 16'd1;
                        row_base_d = row_base_q + H_RES_A;
                    end else begin
                        x_d = x_q;
                    end
                end else begin
                    x_d = x_q;
                end
                // A grant in the abort cycle still counts as a completed write.
                if (iAbort || (iWriteGrant && last_pixel_s)) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_FILL;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign oBusy         = (state_q != S_IDLE);
    assign oDone         = (state_q == S_DONE);
    assign oError        = (state_q == S_DONE) && err_q;
    assign oWriteReq     = (state_q == S_FILL);
    assign oWriteAddress = row_base_q + ADDR_W'(x_q);
    assign oWriteData    = color_q;

endmodule

// File: tb/tb_rect_fill_engine.sv
// Self-checking bench for rect_fill_engine: directed cases plus random rectangles
// compared against a row-major pixel list built from the rectangle corners.
module tb_rect_fill_engine;

    localparam int H_RES   = 80;
    localparam int V_RES   = 60;
    localparam int COLOR_W = 3;
    localparam int ADDR_W  = 13;

    logic               Clock = 1'b0;
    logic               Reset = 1'b0;
    logic               iStart = 1'b0;
    logic               iAbort = 1'b0;
    logic [15:0]        iX0 = 16'd0, iY0 = 16'd0, iX1 = 16'd0, iY1 = 16'd0;
    logic [COLOR_W-1:0] iColor = '0;
    logic               oBusy, oDone, oError, oWriteReq;
    logic               iWriteGrant = 1'b0;
    logic [ADDR_W-1:0]  oWriteAddress;
    logic [COLOR_W-1:0] oWriteData;

    int vectors     = 0;
    int miscompares = 0;

    rect_fill_engine #(
        .H_RES(H_RES), .V_RES(V_RES), .COLOR_W(COLOR_W), .ADDR_W(ADDR_W)
    ) dut (
        .Clock(Clock), .Reset(Reset), .iStart(iStart), .iAbort(iAbort),
        .iX0(iX0), .iY0(iY0), .iX1(iX1), .iY1(iY1), .iColor(iColor),
        .oBusy(oBusy), .oDone(oDone), .oError(oError), .oWriteReq(oWriteReq),
        .iWriteGrant(iWriteGrant), .oWriteAddress(oWriteAddress),
        .oWriteData(oWriteData)
    );

    always #5 Clock = ~Clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // gmode: 0 grant tied high, 1 alternate starting low, 2 random.
    // abort_n: assert abort together with the grant of that write (0 = never).
    // poke: fire extra random iStart strobes while filling.
    task automatic do_cmd(input int x0, input int y0, input int x1, input int y1,
                          input logic [COLOR_W-1:0] col, input int gmode,
                          input int abort_n, input bit poke, input int exp_fill_cyc);
        int exp_q[$];
        bit valid;
        int cyc, writes, stalls, exp_writes, fill_cyc;
        bit done_seen, g;
        valid = (x0 <= x1) && (y0 <= y1) && (x1 < H_RES) && (y1 < V_RES);
        exp_q.delete();
        if (valid) begin
            for (int y = y0; y <= y1; y++)
                for (int x = x0; x <= x1; x++)
                    exp_q.push_back(y * H_RES + x);
        end
        exp_writes = exp_q.size();
        if (abort_n > 0 && abort_n < exp_writes) exp_writes = abort_n;

        @(negedge Clock);
        iStart = 1'b1;
        iX0 = 16'(x0); iY0 = 16'(y0); iX1 = 16'(x1); iY1 = 16'(y1);
        iColor = col;
        @(negedge Clock);
        iStart = 1'b0;
        cyc = 1; writes = 0; stalls = 0; fill_cyc = 0; done_seen = 1'b0;
        while (!done_seen && cyc < 3000) begin
            iStart = 1'b0;
            iAbort = 1'b0;
            if (oDone) begin
                done_seen = 1'b1;
                check_eq("done_cycle", cyc, 2 + exp_writes + stalls);
                check_eq("error_flag", oError, !valid);
                check_eq("write_count", writes, exp_writes);
                check_eq("req_in_done", oWriteReq, 0);
                if (exp_fill_cyc >= 0) check_eq("fill_cycles", fill_cyc, exp_fill_cyc);
                iWriteGrant = 1'(($urandom & 32'd1));
            end else begin
                check_eq("busy", oBusy, 1);
                check_eq("error_early", oError, 0);
                if (cyc == 1) check_eq("req_in_load", oWriteReq, 0);
                if (oWriteReq) begin
                    fill_cyc++;
                    if (writes < exp_q.size()) begin
                        check_eq("addr", oWriteAddress, exp_q[writes]);
                    end else begin
                        check_eq("extra_write", 1, 0);
                    end
                    check_eq("data", oWriteData, col);
                    case (gmode)
                        0: g = 1'b1;
                        1: g = (fill_cyc % 2) == 0;
                        default: g = ($urandom_range(0, 3) != 0);
                    endcase
                    iWriteGrant = g;
                    if (g) begin
                        writes++;
                        if (abort_n > 0 && writes == abort_n) iAbort = 1'b1;
                    end else begin
                        stalls++;
                    end
                    if (poke) begin
                        iStart = 1'(($urandom & 32'd1));
                        iX0 = 16'($urandom_range(0, 79)); iY0 = 16'($urandom_range(0, 59));
                        iX1 = iX0; iY1 = iY0;
                        iColor = 3'($urandom);
                    end
                end else begin
                    iWriteGrant = 1'(($urandom & 32'd1));
                end
            end
            @(negedge Clock);
            cyc++;
        end
        iStart = 1'b0;
        iAbort = 1'b0;
        if (!done_seen) check_eq("done_timeout", 0, 1);
        check_eq("idle_busy", oBusy, 0);
        check_eq("idle_done", oDone, 0);
    endtask

    initial begin
        Reset = 1'b0;
        #12;
        check_eq("rst_busy", oBusy, 0);
        check_eq("rst_done", oDone, 0);
        check_eq("rst_error", oError, 0);
        check_eq("rst_req", oWriteReq, 0);
        check_eq("rst_addr", oWriteAddress, 0);
        check_eq("rst_data", oWriteData, 0);
        @(negedge Clock);
        Reset = 1'b1;

        // Directed cases.
        do_cmd(5, 7, 5, 7, 3'b010, 0, 0, 1'b0, 1);
        do_cmd(0, 0, 79, 14, 3'b101, 0, 0, 1'b0, 1200);
        do_cmd(2, 1, 3, 2, 3'b111, 1, 0, 1'b0, 8);
        do_cmd(10, 0, 9, 0, 3'b001, 0, 0, 1'b0, 0);
        do_cmd(0, 0, 80, 0, 3'b001, 0, 0, 1'b0, 0);
        do_cmd(0, 3, 0, 60, 3'b001, 2, 0, 1'b0, 0);
        do_cmd(20, 5, 25, 6, 3'b011, 0, 0, 1'b1, 12);
        do_cmd(0, 0, 9, 0, 3'b110, 0, 3, 1'b0, 3);
        do_cmd(78, 58, 79, 59, 3'b100, 2, 0, 1'b1, -1);

        // Asynchronous reset in the middle of a fill.
        @(negedge Clock);
        iStart = 1'b1; iX0 = 16'd0; iY0 = 16'd0; iX1 = 16'd79; iY1 = 16'd59;
        iWriteGrant = 1'b1;
        @(negedge Clock);
        iStart = 1'b0;
        repeat (5) @(negedge Clock);
        check_eq("pre_rst_req", oWriteReq, 1);
        #2;
        Reset = 1'b0;
        #1;
        check_eq("async_req", oWriteReq, 0);
        check_eq("async_busy", oBusy, 0);
        check_eq("async_addr", oWriteAddress, 0);
        @(negedge Clock);
        check_eq("held_req", oWriteReq, 0);
        Reset = 1'b1;
        do_cmd(0, 59, 0, 59, 3'b011, 0, 0, 1'b0, 1);

        // Random rectangles, some deliberately out of range or inverted.
        for (int n = 0; n < 40; n++) begin
            int rx0, ry0, rx1, ry1, ab;
            rx0 = $urandom_range(0, 82);
            ry0 = $urandom_range(0, 61);
            rx1 = rx0 + $urandom_range(0, 5) - (($urandom_range(0, 7) == 0) ? 2 : 0);
            ry1 = ry0 + $urandom_range(0, 3) - (($urandom_range(0, 7) == 0) ? 1 : 0);
            if (rx1 < 0) rx1 = 0;
            if (ry1 < 0) ry1 = 0;
            ab = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 6) : 0;
            do_cmd(rx0, ry0, rx1, ry1, 3'($urandom), $urandom_range(0, 2), ab,
                   1'(($urandom & 32'd1)), -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rect_fill_engine.md
# rect_fill_engine

Hardware rectangle-fill sequencer for the VGA video RAM write port. It offloads the CPU's nested pixel loop: the CPU latches a rectangle and a colour, pulses start, and the engine writes every pixel in row-major order through a request/grant port. That port is shared with the CPU `VGA` write path, and the port arbiter owns the grant. Completion is signalled by a one-cycle done pulse, so the program can poll or wait instead of looping over pixels.

## Interface
- `H_RES`, 80, pixels per row; video RAM address = y*H_RES + x.
- `V_RES`, 60, rows.
- `COLOR_W`, 3, colour width (RGB).
- `ADDR_W`, 13, video RAM address width; H_RES*V_RES ≤ 2^ADDR_W.
- `Clock`  in  1  single clock; all state on rising edge.
- `Reset`  in  1  asynchronous, active-low reset.
- `iStart`  in  1  command strobe, sampled only in IDLE.
- `iAbort`  in  1  terminate current fill.
- `iX0`, `iY0`, `iX1`, `iY1`  in  16 each  inclusive corners (unsigned).
- `iColor`  in  COLOR_W  fill colour.
- `oBusy`  out  1  high whenever state ≠ IDLE.
- `oDone`  out  1  one-cycle completion pulse.
- `oError`  out  1  one-cycle pulse, rejected command; coincides with `oDone`.
- `oWriteReq`  out  1  pixel write request.
- `iWriteGrant`  in  1  arbiter grant; write happens on req&grant edge.
- `oWriteAddress`  out  ADDR_W  pixel address.
- `oWriteData`  out  COLOR_W  pixel colour.

## Operation
- States: IDLE, LOAD, FILL, DONE.
- IDLE: on `iStart`, latch corners and colour, go to LOAD. `iStart` in any other state is ignored.
- LOAD (1 cycle) checks the command:
  - Invalid if X0>X1, Y0>Y1, X1≥H_RES or Y1≥V_RES. Go to DONE with the error flag set; no write is ever requested.
  - Otherwise: rowBase = Y0*H_RES (the only multiply), x=X0, y=Y0, then go to FILL.
- FILL: `oWriteReq`=1, `oWriteAddress`=rowBase+x, `oWriteData`=latched colour. These are held stable until granted.
- On a cycle with `iWriteGrant`=1:
  - x<X1: x++.
  - x==X1, y<Y1: x=X0, y++, rowBase+=H_RES.
  - x==X1, y==Y1: go to DONE.
- `iAbort` in LOAD or FILL goes to DONE.
  - Abort and grant in the same cycle: that pixel counts as written.
  - `iAbort` in IDLE or DONE is ignored.
- DONE (1 cycle): `oDone`=1, and `oError`=1 if the command was rejected. Then go to IDLE.
- Internal x/y/rowBase use ADDR_W/16-bit unsigned arithmetic. Validation guarantees there is no overflow or wrap-around.

## Timing
- Reset values: state IDLE; `oBusy`, `oDone`, `oError`, `oWriteReq` = 0; `oWriteAddress`, `oWriteData` = 0.
- Reset mid-fill: outputs clear asynchronously, no further requests, and the next `iStart` after release is accepted.
- Outputs are registered or decoded from registered state only. There is no combinational path from `iWriteGrant` to `oWriteReq`/`oWriteAddress`.
- Latency, with `iStart` sampled at edge 0:
  - LOAD during cycle 1.
  - First request during cycle 2.
  - With grant held high, N pixels take cycles 2..N+1.
  - `oDone` during cycle N+2; `oBusy` low from cycle N+3.
- Throughput: 1 pixel/cycle with continuous grant. Each grant-low cycle adds one cycle of stall.
- Rejected command: `oDone`+`oError` during cycle 2, `oBusy` high in cycles 1–2.

## Test plan
- Single pixel: (5,7)-(5,7), colour 3'b010, grant tied 1 → exactly one write, addr 565, data 010; `oDone` in cycle 3; `oBusy` cycles 1–3.
- Full band: (0,0)-(79,14), grant tied 1 → 1200 writes, addresses 0..1199 strictly consecutive; `oDone` in cycle 1202; no `oError`.
- Grant stall: (2,1)-(3,2), grant alternating 0/1 starting at 0 → addresses 82, 83, 162, 163 in order; address/data stable across each ungranted cycle; 8 FILL cycles.
- Rejects: (10,0)-(9,0) and (0,0)-(80,0) → `oWriteReq` never 1; `oDone`&`oError` together in cycle 2.
- Start ignored / abort: second `iStart` during a fill → no effect. `iAbort` with grant on the 3rd write of (0,0)-(9,0) → exactly 3 writes (0,1,2), `oDone` next cycle, no `oError`.
- Async reset: drop `Reset` mid-fill between edges → `oWriteReq`/`oBusy` go 0 immediately. After release, a fresh (0,59)-(0,59) start writes addr 4720.
